// File: rtl/vector_writeback_unit_pkg.sv
// Shared encodings for the vector write-back path: function-unit status
// values and the write-back sequencer states.
package vector_writeback_unit_pkg;

    localparam logic [1:0] VEC_ALU_NOP      = 2'b00;
    localparam logic [1:0] VEC_ALU_WORKING  = 2'b01;
    localparam logic [1:0] VEC_ALU_FINISHED = 2'b10;

    localparam logic [0:0] WB_IDLE  = 1'b0;
    localparam logic [0:0] WB_WRITE = 1'b1;

endpackage

// File: rtl/vector_wb_slot.sv
// One buffered write-back request: result vector, length, destination,
// mask controls and a valid flag. Load wins over clear on the same edge.
module vector_wb_slot #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int VREG_INDEX_SIZE  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic                            clear,
    input  logic [VECTOR_SIZE*LEN-1:0]      d_data,
    input  logic [ENTRY_INDEX_SIZE:0]       d_len,
    input  logic [VREG_INDEX_SIZE-1:0]      d_vd,
    input  logic                            d_vm,
    input  logic [VECTOR_SIZE-1:0]          d_mask,
    output logic [VECTOR_SIZE*LEN-1:0]      q_data,
    output logic [ENTRY_INDEX_SIZE:0]       q_len,
    output logic [VREG_INDEX_SIZE-1:0]      q_vd,
    output logic                            q_vm,
    output logic [VECTOR_SIZE-1:0]          q_mask,
    output logic                            q_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_data  <= '0;
            q_len   <= '0;
            q_vd    <= '0;
            q_vm    <= 1'b0;
            q_mask  <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_data  <= d_data;
            q_len   <= d_len;
            q_vd    <= d_vd;
            q_vm    <= d_vm;
            q_mask  <= d_mask;
            q_valid <= 1'b1;
        end else if (clear) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Buffers finished vector results (active + pending slot) and streams them
// into the register file WB_LANES elements per beat, honouring length and mask.
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int VREG_INDEX_SIZE  = 5,
    parameter int WB_LANES         = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy_in,
    input  logic [1:0]                      vector_alu_status,
    input  logic [VECTOR_SIZE*LEN-1:0]      alu_result,
    input  logic [ENTRY_INDEX_SIZE:0]       length,
    input  logic [VREG_INDEX_SIZE-1:0]      vd_index,
    input  logic                            vm,
    input  logic [VECTOR_SIZE-1:0]          mask_bits,
    output logic                            vrf_we,
    output logic [VREG_INDEX_SIZE-1:0]      vrf_vreg,
    output logic [ENTRY_INDEX_SIZE:0]       vrf_elem_base,
    output logic [WB_LANES-1:0]             vrf_elem_we,
    output logic [WB_LANES*LEN-1:0]         vrf_wdata,
    output logic                            wb_done,
    output logic [VREG_INDEX_SIZE-1:0]      wb_vreg,
    output logic                            accept_ready,
    output logic                            busy,
    output logic                            overrun
);

    localparam int LW = ENTRY_INDEX_SIZE + 1;
    localparam int VW = VECTOR_SIZE * LEN;

    logic [VW-1:0]              act_data, pend_data, act_d_data;
    logic [LW-1:0]              act_len, pend_len, act_d_len;
    logic [VREG_INDEX_SIZE-1:0] act_vd, pend_vd, act_d_vd;
    logic                       act_vm, pend_vm, act_d_vm;
    logic [VECTOR_SIZE-1:0]     act_mask, pend_mask, act_d_mask;
    logic                       act_valid, pend_valid;

    logic [0:0]                 state;
    logic [LW-1:0]              ptr;

    logic                       cap_valid;
    logic [LW-1:0]              cap_len;
    logic                       complete;
    logic                       idle_load;
    logic                       issue;

    logic                       act_load, act_from_pend, act_clear;
    logic                       pend_load, pend_clear, overrun_set;

    logic [VW-1:0]              src_data;
    logic [LW-1:0]              src_len, src_ptr;
    logic [VREG_INDEX_SIZE-1:0] src_vd;
    logic                       src_vm;
    logic [VECTOR_SIZE-1:0]     src_mask;

    logic [LW-1:0]              lane_idx;
    logic [WB_LANES-1:0]        beat_we;
    logic [WB_LANES*LEN-1:0]    beat_data;

    assign cap_valid = (vector_alu_status == VEC_ALU_FINISHED) && (length != '0);

    always_comb begin
        cap_len = length;
        if (length > LW'(VECTOR_SIZE)) begin
            cap_len = LW'(VECTOR_SIZE);
        end
    end

    // The pointer already sits past the last beat once it has been issued,
    // so the following edge is the completion edge.
    assign complete  = (state == WB_WRITE) && rdy_in && (ptr >= act_len);
    assign idle_load = (state == WB_IDLE) && cap_valid;
    assign issue     = rdy_in && (idle_load || ((state == WB_WRITE) && (ptr < act_len)));

    always_comb begin
        act_load      = 1'b0;
        act_from_pend = 1'b0;
        act_clear     = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        overrun_set   = 1'b0;
        if (complete) begin
            if (pend_valid) begin
                act_load      = 1'b1;
                act_from_pend = 1'b1;
                pend_clear    = 1'b1;
                pend_load     = cap_valid;
            end else begin
                act_clear = 1'b1;
                act_load  = cap_valid;
            end
        end else if (cap_valid) begin
            if (!act_valid) begin
                act_load = 1'b1;
            end else if (!pend_valid) begin
                pend_load = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end
    end

    always_comb begin
        act_d_data = alu_result;
        act_d_len  = cap_len;
        act_d_vd   = vd_index;
        act_d_vm   = vm;
        act_d_mask = mask_bits;
        if (act_from_pend) begin
            act_d_data = pend_data;
            act_d_len  = pend_len;
            act_d_vd   = pend_vd;
            act_d_vm   = pend_vm;
            act_d_mask = pend_mask;
        end
    end

    vector_wb_slot #(
        .LEN              (LEN),
        .VECTOR_SIZE      (VECTOR_SIZE),
        .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE),
        .VREG_INDEX_SIZE  (VREG_INDEX_SIZE)
    ) u_active_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (act_load),
        .clear   (act_clear),
        .d_data  (act_d_data),
        .d_len   (act_d_len),
        .d_vd    (act_d_vd),
        .d_vm    (act_d_vm),
        .d_mask  (act_d_mask),
        .q_data  (act_data),
        .q_len   (act_len),
        .q_vd    (act_vd),
        .q_vm    (act_vm),
        .q_mask  (act_mask),
        .q_valid (act_valid)
    );

    vector_wb_slot #(
        .LEN              (LEN),
        .VECTOR_SIZE      (VECTOR_SIZE),
        .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE),
        .VREG_INDEX_SIZE  (VREG_INDEX_SIZE)
    ) u_pending_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (pend_load),
        .clear   (pend_clear),
        .d_data  (alu_result),
        .d_len   (cap_len),
        .d_vd    (vd_index),
        .d_vm    (vm),
        .d_mask  (mask_bits),
        .q_data  (pend_data),
        .q_len   (pend_len),
        .q_vd    (pend_vd),
        .q_vm    (pend_vm),
        .q_mask  (pend_mask),
        .q_valid (pend_valid)
    );

    // Capturing into an idle unit issues beat 0 straight from the incoming
    // result, which is what gives the one-cycle capture-to-beat latency.
    always_comb begin
        src_data = act_data;
        src_len  = act_len;
        src_vd   = act_vd;
        src_vm   = act_vm;
        src_mask = act_mask;
        src_ptr  = ptr;
        if (idle_load) begin
            src_data = alu_result;
            src_len  = cap_len;
            src_vd   = vd_index;
            src_vm   = vm;
            src_mask = mask_bits;
            src_ptr  = '0;
        end
    end

    always_comb begin
        lane_idx  = '0;
        beat_we   = '0;
        beat_data = '0;
        for (int j = 0; j < WB_LANES; j++) begin
            lane_idx = src_ptr + LW'(j);
            if (lane_idx < src_len) begin
                beat_we[j] = src_vm || src_mask[lane_idx[ENTRY_INDEX_SIZE-1:0]];
            end
            beat_data[j*LEN +: LEN] = src_data[32'(lane_idx[ENTRY_INDEX_SIZE-1:0])*LEN +: LEN];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WB_IDLE;
            ptr   <= '0;
        end else begin
            state <= (act_load || (act_valid && !act_clear)) ? WB_WRITE : WB_IDLE;
            if (complete) begin
                ptr <= '0;
            end else if (issue) begin
                ptr <= src_ptr + LW'(WB_LANES);
            end
        end
    end

    // A stall freezes the beat outputs but must never repeat a write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vrf_we        <= 1'b0;
            vrf_vreg      <= '0;
            vrf_elem_base <= '0;
            vrf_elem_we   <= '0;
            vrf_wdata     <= '0;
            wb_done       <= 1'b0;
            wb_vreg       <= '0;
        end else if (!rdy_in) begin
            vrf_we  <= 1'b0;
            wb_done <= 1'b0;
        end else begin
            wb_done <= complete;
            if (complete) begin
                wb_vreg <= act_vd;
            end
            if (issue) begin
                vrf_we        <= |beat_we;
                vrf_vreg      <= src_vd;
                vrf_elem_base <= src_ptr;
                vrf_elem_we   <= beat_we;
                vrf_wdata     <= beat_data;
            end else begin
                vrf_we      <= 1'b0;
                vrf_elem_we <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end
    end

    assign accept_ready = !pend_valid;
    assign busy         = act_valid;

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Directed bench for vector_writeback_unit: a scoreboard of expected beats
// and completions is filled at stimulus time and drained by a monitor.
module tb_vector_writeback_unit;

    logic         clk;
    logic         rst;
    logic         rdy_in;
    logic [1:0]   vector_alu_status;
    logic [255:0] alu_result;
    logic [3:0]   length;
    logic [4:0]   vd_index;
    logic         vm;
    logic [7:0]   mask_bits;
    logic         vrf_we;
    logic [4:0]   vrf_vreg;
    logic [3:0]   vrf_elem_base;
    logic [1:0]   vrf_elem_we;
    logic [63:0]  vrf_wdata;
    logic         wb_done;
    logic [4:0]   wb_vreg;
    logic         accept_ready;
    logic         busy;
    logic         overrun;

    typedef struct {
        logic [3:0]  base;
        logic [1:0]  we;
        logic [4:0]  vreg;
        logic [63:0] data;
    } beat_t;

    beat_t      beatQ[$];
    logic [4:0] doneQ[$];
    beat_t      monBeat;
    logic [4:0] monVreg;
    int         checks = 0;
    int         fails  = 0;

    vector_writeback_unit dut (
        .clk               (clk),
        .rst               (rst),
        .rdy_in            (rdy_in),
        .vector_alu_status (vector_alu_status),
        .alu_result        (alu_result),
        .length            (length),
        .vd_index          (vd_index),
        .vm                (vm),
        .mask_bits         (mask_bits),
        .vrf_we            (vrf_we),
        .vrf_vreg          (vrf_vreg),
        .vrf_elem_base     (vrf_elem_base),
        .vrf_elem_we       (vrf_elem_we),
        .vrf_wdata         (vrf_wdata),
        .wb_done           (wb_done),
        .wb_vreg           (wb_vreg),
        .accept_ready      (accept_ready),
        .busy              (busy),
        .overrun           (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected beats follow the element rule: lane j of beat p writes when
    // p+j is inside the length and the element is unmasked or vm is set.
    task automatic pushExpected(input logic [3:0] len, input logic [4:0] vd, input logic useVm,
                                input logic [7:0] mask, input logic [31:0] dataBase);
        int    l;
        beat_t b;
        l = (int'(len) > 8) ? 8 : int'(len);
        for (int p = 0; p < l; p += 2) begin
            b.base = 4'(p);
            b.we   = 2'b00;
            b.vreg = vd;
            b.data = {dataBase + 32'(p + 1), dataBase + 32'(p)};
            for (int j = 0; j < 2; j++) begin
                if ((p + j < l) && (useVm || mask[p + j])) b.we[j] = 1'b1;
            end
            if (b.we != 2'b00) beatQ.push_back(b);
        end
        if (l > 0) doneQ.push_back(vd);
    endtask

    task automatic applyStimulus(input logic [3:0] len, input logic [4:0] vd, input logic useVm,
                                 input logic [7:0] mask, input logic [31:0] dataBase, input bit accepted);
        for (int i = 0; i < 8; i++) alu_result[i*32 +: 32] = dataBase + 32'(i);
        length            = len;
        vd_index          = vd;
        vm                = useVm;
        mask_bits         = mask;
        vector_alu_status = 2'b10;
        if (accepted) pushExpected(len, vd, useVm, mask, dataBase);
        nextCycle();
        vector_alu_status = 2'b00;
    endtask

    task automatic waitDrain(input string tag);
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 80 && !drained; i++) begin
            @(negedge clk);
            #1;
            if (!busy && beatQ.size() == 0 && doneQ.size() == 0) drained = 1'b1;
        end
        checkOutput(tag, 64'(drained), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (vrf_we === 1'b1) begin
                if (beatQ.size() == 0) begin
                    checkOutput("stray beat, expected beats queued", 64'(beatQ.size()), 64'd1);
                end else begin
                    monBeat = beatQ.pop_front();
                    checkOutput("beat base", 64'(vrf_elem_base), 64'(monBeat.base));
                    checkOutput("beat elem_we", 64'(vrf_elem_we), 64'(monBeat.we));
                    checkOutput("beat vreg", 64'(vrf_vreg), 64'(monBeat.vreg));
                    checkOutput("beat wdata", vrf_wdata, monBeat.data);
                end
            end
            if (wb_done === 1'b1) begin
                if (doneQ.size() == 0) begin
                    checkOutput("stray wb_done, expected completions queued", 64'(doneQ.size()), 64'd1);
                end else begin
                    monVreg = doneQ.pop_front();
                    checkOutput("wb_vreg", 64'(wb_vreg), 64'(monVreg));
                end
            end
        end
    end

    initial begin
        rst               = 1'b0;
        rdy_in            = 1'b1;
        vector_alu_status = 2'b00;
        alu_result        = '0;
        length            = '0;
        vd_index          = '0;
        vm                = 1'b1;
        mask_bits         = '0;
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("reset vrf_we", 64'(vrf_we), 64'd0);
        checkOutput("reset elem_we", 64'(vrf_elem_we), 64'd0);
        checkOutput("reset wdata", vrf_wdata, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset overrun", 64'(overrun), 64'd0);
        checkOutput("reset wb_done", 64'(wb_done), 64'd0);
        rst = 1'b1;

        // Unmasked len=5: beats at cycles 1-3, done at cycle 4.
        applyStimulus(4'd5, 5'd3, 1'b1, 8'h00, 32'h100, 1'b1);
        @(negedge clk);
        checkOutput("t1 c1 base", 64'(vrf_elem_base), 64'd0);
        checkOutput("t1 c1 elem_we", 64'(vrf_elem_we), 64'b11);
        checkOutput("t1 c1 accept_ready", 64'(accept_ready), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 c2 base", 64'(vrf_elem_base), 64'd2);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 c3 base", 64'(vrf_elem_base), 64'd4);
        checkOutput("t1 c3 elem_we", 64'(vrf_elem_we), 64'b01);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 c4 wb_done", 64'(wb_done), 64'd1);
        checkOutput("t1 c4 vrf_we", 64'(vrf_we), 64'd0);
        waitDrain("t1 drain");

        // Masked writes, including beats that are fully masked off.
        applyStimulus(4'd8, 5'd4, 1'b0, 8'hA5, 32'h200, 1'b1);
        waitDrain("t2a drain");
        applyStimulus(4'd8, 5'd6, 1'b0, 8'hC2, 32'h280, 1'b1);
        @(negedge clk);
        checkOutput("t2b c1 elem_we", 64'(vrf_elem_we), 64'b10);
        nextCycle();
        @(negedge clk);
        checkOutput("t2b c2 base", 64'(vrf_elem_base), 64'd2);
        checkOutput("t2b c2 vrf_we", 64'(vrf_we), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2b c3 vrf_we", 64'(vrf_we), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2b c4 elem_we", 64'(vrf_elem_we), 64'b11);
        nextCycle();
        @(negedge clk);
        checkOutput("t2b c5 wb_done", 64'(wb_done), 64'd1);
        waitDrain("t2b drain");

        // Back-to-back completions two cycles apart.
        applyStimulus(4'd8, 5'd3, 1'b1, 8'h00, 32'h300, 1'b1);
        nextCycle();
        applyStimulus(4'd8, 5'd7, 1'b1, 8'h00, 32'h400, 1'b1);
        @(negedge clk);
        checkOutput("t3 c3 accept_ready", 64'(accept_ready), 64'd0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("t3 c5 wb_done", 64'(wb_done), 64'd1);
        checkOutput("t3 c5 vrf_we", 64'(vrf_we), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t3 c6 vrf_we", 64'(vrf_we), 64'd1);
        checkOutput("t3 c6 vreg", 64'(vrf_vreg), 64'd7);
        checkOutput("t3 c6 base", 64'(vrf_elem_base), 64'd0);
        waitDrain("t3 drain");
        checkOutput("t3 overrun", 64'(overrun), 64'd0);

        // Third completion with both slots occupied is dropped.
        applyStimulus(4'd8, 5'd1, 1'b1, 8'h00, 32'h500, 1'b1);
        applyStimulus(4'd6, 5'd2, 1'b1, 8'h00, 32'h600, 1'b1);
        applyStimulus(4'd8, 5'd9, 1'b1, 8'h00, 32'h700, 1'b0);
        @(negedge clk);
        checkOutput("t4 overrun set", 64'(overrun), 64'd1);
        waitDrain("t4 drain");
        checkOutput("t4 overrun sticky", 64'(overrun), 64'd1);

        // Three-cycle stall after the first beat.
        applyStimulus(4'd8, 5'd5, 1'b1, 8'h00, 32'h800, 1'b1);
        rdy_in = 1'b0;
        @(negedge clk);
        checkOutput("t5 beat0 vrf_we", 64'(vrf_we), 64'd1);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            @(negedge clk);
            checkOutput("t5 stall vrf_we", 64'(vrf_we), 64'd0);
            checkOutput("t5 stall base", 64'(vrf_elem_base), 64'd0);
        end
        rdy_in = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("t5 resume base", 64'(vrf_elem_base), 64'd2);
        checkOutput("t5 resume vrf_we", 64'(vrf_we), 64'd1);
        waitDrain("t5 drain");

        // Zero length is ignored; oversize length clamps to the vector size.
        applyStimulus(4'd0, 5'd10, 1'b1, 8'h00, 32'h900, 1'b1);
        @(negedge clk);
        checkOutput("t6 len0 busy", 64'(busy), 64'd0);
        applyStimulus(4'd12, 5'd12, 1'b1, 8'h00, 32'hA00, 1'b1);
        @(negedge clk);
        checkOutput("t6 clamp busy", 64'(busy), 64'd1);
        waitDrain("t6 drain");

        // Reset during beat base=2 with the pending slot occupied.
        applyStimulus(4'd8, 5'd4, 1'b1, 8'h00, 32'hB00, 1'b1);
        applyStimulus(4'd8, 5'd6, 1'b1, 8'h00, 32'hC00, 1'b1);
        #2;
        rst = 1'b0;
        beatQ.delete();
        doneQ.delete();
        #1;
        checkOutput("t7 rst vrf_we", 64'(vrf_we), 64'd0);
        checkOutput("t7 rst base", 64'(vrf_elem_base), 64'd0);
        checkOutput("t7 rst elem_we", 64'(vrf_elem_we), 64'd0);
        checkOutput("t7 rst wdata", vrf_wdata, 64'd0);
        checkOutput("t7 rst vreg", 64'(vrf_vreg), 64'd0);
        checkOutput("t7 rst busy", 64'(busy), 64'd0);
        checkOutput("t7 rst overrun", 64'(overrun), 64'd0);
        repeat (2) nextCycle();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) nextCycle();
        @(negedge clk);
        checkOutput("t7 idle busy", 64'(busy), 64'd0);
        applyStimulus(4'd3, 5'd11, 1'b0, 8'h05, 32'hD00, 1'b1);
        waitDrain("t7 post-reset drain");

        checkOutput("final scoreboard empty", 64'(beatQ.size() + doneQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
